// File: rtl/rr_dist_pkg.sv
// rr_dist_pkg: shared sizing constants and channel index type for rr_fifo_distributor.
`default_nettype none

package rr_dist_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int N_CH   = 4;
  localparam int PTR_W  = 3;
  localparam int CNT_W  = 4;

  typedef logic [1:0] ch_idx_t;
endpackage

`default_nettype wire

// File: rtl/dist_fifo.sv
// dist_fifo: synchronous FIFO with registered, zero-when-idle read data and a drop flag.
`default_nettype none

module dist_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              do_wr;
  logic              do_rd;

  // Full/empty come from the start-of-cycle count, so a same-edge
  // read cannot make room for a write and vice versa.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wen && !full;
  assign do_rd = ren && !empty;
  assign drop  = wen && full;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_rd) begin
        rptr  <= rptr + PTR_W'(1);
        dout  <= mem[rptr];
        valid <= 1'b1;
      end else begin
        dout  <= '0;
        valid <= 1'b0;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/rr_fifo_distributor.sv
// rr_fifo_distributor: fans one write stream round-robin across four channel FIFOs.
`default_nettype none

module rr_fifo_distributor #(
  parameter int DATA_W = rr_dist_pkg::DATA_W,
  parameter int DEPTH  = rr_dist_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        ren,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic [3:0]        valid,
  output logic [3:0]        full,
  output logic [3:0]        empty,
  output logic              err,
  output logic [1:0]        sel
);
  import rr_dist_pkg::ch_idx_t;
  import rr_dist_pkg::N_CH;

  logic [DATA_W-1:0] dout [N_CH];
  logic [N_CH-1:0]   ch_wen;
  logic [N_CH-1:0]   drop;

  // sel moves on every write request, accepted or dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel <= '0;
      err <= 1'b0;
    end else begin
      if (wen) begin
        sel <= sel + 2'd1;
      end
      err <= |drop;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_wen[i] = wen && (ch_idx_t'(sel) == ch_idx_t'(i));

    dist_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (ch_wen[i]),
      .ren   (ren[i]),
      .din   (din),
      .dout  (dout[i]),
      .valid (valid[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .drop  (drop[i])
    );
  end

  assign a = dout[0];
  assign b = dout[1];
  assign c = dout[2];
  assign d = dout[3];
endmodule

`default_nettype wire

// File: tb/tb_rr_fifo_distributor.sv
// tb_rr_fifo_distributor: directed self-checking bench for rr_fifo_distributor.
`default_nettype none

module tb_rr_fifo_distributor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen;
  logic [7:0] din;
  logic [3:0] ren;
  logic [7:0] a, b, c, d;
  logic [3:0] valid, full, empty;
  logic       err;
  logic [1:0] sel;

  int tests = 0;
  int fails = 0;

  rr_fifo_distributor #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren),
    .a(a), .b(b), .c(c), .d(d), .valid(valid), .full(full),
    .empty(empty), .err(err), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic w, input logic [7:0] dd, input logic [3:0] r);
    wen = w; din = dd; ren = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 8'h00, 4'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b1, 8'hFF, 4'hF);
    tick(1'b1, 8'hFF, 4'hF);
    rst_n = 1'b1;
    tests++; if ({a, b, c, d} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 00000000", {a, b, c, d}); end
    tests++; if (valid !== 4'h0 || err !== 1'b0 || sel !== 2'd0) begin fails++; $display("FAIL reset_ctrl: got valid=%b err=%b sel=%0d expected 0000/0/0", valid, err, sel); end
    tests++; if (full !== 4'h0 || empty !== 4'hF) begin fails++; $display("FAIL reset_flags: got full=%b empty=%b expected 0000/1111", full, empty); end
  endtask

  task automatic test_rr_basic();
    do_reset();
    tick(1'b1, 8'h11, 4'h0);
    tick(1'b1, 8'h22, 4'h0);
    tick(1'b1, 8'h33, 4'h0);
    tick(1'b1, 8'h44, 4'h0);
    tests++; if (sel !== 2'd0 || empty !== 4'h0) begin fails++; $display("FAIL rr_after_writes: got sel=%0d empty=%b expected 0/0000", sel, empty); end
    tick(1'b0, 8'h00, 4'hF);
    tests++; if ({a, b, c, d} !== 32'h11223344) begin fails++; $display("FAIL rr_read_data: got %h expected 11223344", {a, b, c, d}); end
    tests++; if (valid !== 4'hF) begin fails++; $display("FAIL rr_read_valid: got %b expected 1111", valid); end
    tick(1'b0, 8'h00, 4'h0);
    tests++; if (valid !== 4'h0 || {a, b, c, d} !== 32'h0 || empty !== 4'hF) begin fails++; $display("FAIL rr_idle: got valid=%b data=%h empty=%b expected 0000/00000000/1111", valid, {a, b, c, d}, empty); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) tick(1'b1, 8'(i), 4'h0);
    tests++; if (full !== 4'hF || err !== 1'b0 || sel !== 2'd0) begin fails++; $display("FAIL fill_32: got full=%b err=%b sel=%0d expected 1111/0/0", full, err, sel); end
    tick(1'b1, 8'hAA, 4'h0);
    tests++; if (err !== 1'b1 || sel !== 2'd1 || full !== 4'hF) begin fails++; $display("FAIL overflow_drop: got err=%b sel=%0d full=%b expected 1/1/1111", err, sel, full); end
    // channel 1 full: same-edge write is dropped, read of oldest (0x01) succeeds
    tick(1'b1, 8'hEE, 4'h2);
    tests++; if (b !== 8'h01 || valid !== 4'h2 || err !== 1'b1 || full !== 4'hD) begin fails++; $display("FAIL full_wr_rd: got b=%h valid=%b err=%b full=%b expected 01/0010/1/1101", b, valid, err, full); end
    tick(1'b0, 8'h00, 4'h0);
    tests++; if (err !== 1'b0 || sel !== 2'd2) begin fails++; $display("FAIL err_clear: got err=%b sel=%0d expected 0/2", err, sel); end
  endtask

  task automatic test_empty_read();
    do_reset();
    tick(1'b1, 8'h77, 4'h0);
    tick(1'b0, 8'h00, 4'h4);
    tests++; if (c !== 8'h00 || valid !== 4'h0 || empty[2] !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL empty_read: got c=%h valid=%b empty2=%b err=%b expected 00/0000/1/0", c, valid, empty[2], err); end
    tests++; if (empty !== 4'hE) begin fails++; $display("FAIL empty_other: got empty=%b expected 1110", empty); end
  endtask

  task automatic test_same_edge();
    do_reset();
    tick(1'b1, 8'hA5, 4'h0);
    tick(1'b1, 8'h01, 4'h0);
    tick(1'b1, 8'h02, 4'h0);
    tick(1'b1, 8'h03, 4'h0);
    tick(1'b1, 8'h5A, 4'h1);
    tests++; if (a !== 8'hA5 || valid !== 4'h1 || empty[0] !== 1'b0) begin fails++; $display("FAIL same_edge: got a=%h valid=%b empty0=%b expected a5/0001/0", a, valid, empty[0]); end
    tick(1'b0, 8'h00, 4'h1);
    tests++; if (a !== 8'h5A || valid[0] !== 1'b1 || empty[0] !== 1'b1) begin fails++; $display("FAIL same_edge_next: got a=%h valid0=%b empty0=%b expected 5a/1/1", a, valid[0], empty[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 8'(k), 4'h8);
      tick(1'b1, 8'h00, 4'h1);
      tests++; if (a !== 8'(k) || valid[0] !== 1'b1) begin fails++; $display("FAIL wrap_read_%0d: got a=%h valid0=%b expected %h/1", k, a, valid[0], 8'(k)); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL wrap_err_%0d: got err=%b expected 0", k, err); end
      tick(1'b1, 8'h00, 4'h2);
      tick(1'b1, 8'h00, 4'h4);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(1'b1, 8'h31, 4'h0);
    tick(1'b1, 8'h32, 4'h0);
    tick(1'b1, 8'h33, 4'h0);
    rst_n = 1'b0;
    tick(1'b1, 8'h34, 4'h0);
    rst_n = 1'b1;
    tests++; if (sel !== 2'd0 || empty !== 4'hF || full !== 4'h0) begin fails++; $display("FAIL mid_reset_state: got sel=%0d empty=%b full=%b expected 0/1111/0000", sel, empty, full); end
    tick(1'b0, 8'h00, 4'hF);
    tests++; if (valid !== 4'h0 || {a, b, c, d} !== 32'h0) begin fails++; $display("FAIL mid_reset_read: got valid=%b data=%h expected 0000/00000000", valid, {a, b, c, d}); end
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; din = 8'h00; ren = 4'h0;
    #2;
    test_reset();
    test_rr_basic();
    test_fill_overflow();
    test_empty_read();
    test_same_edge();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
